fib_majority_sequencer: RTL
===========================

Name: fib_majority_sequencer

Overview:
Sequential controller for the Fibonacci-majority check. A single shared 4-bit Fibonacci classifier replaces thirteen parallel copies.
- Accepts N_INPUTS 4-bit values one per handshake after a start command.
- Counts how many accepted values are Fibonacci numbers.
- Reports whether they form a strict majority.
- Sits between a serial data source and downstream logic that consumes the majority flag.

Parameters:
N_INPUTS, 13, number of values per frame; must be odd, range 1..63
CW, $clog2(N_INPUTS+1), width of the Fibonacci count and the sample index

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a new frame; honoured only in IDLE
in_valid  in  1  in_data carries a sample
in_data  in  4  unsigned sample value
in_ready  out  1  sequencer accepts a sample this cycle
busy  out  1  high in COLLECT and DECIDE
done  out  1  one-cycle pulse: frame result valid
majority  out  1  1 when the Fibonacci count is greater than N_INPUTS/2 (integer division)
fib_count  out  CW  Fibonacci count of the last completed frame

Behaviour:
- Reset (rst=1 at a clock edge, in any state):
  - state=IDLE.
  - in_ready=0, busy=0, done=0, majority=0, fib_count=0.
  - Internal idx=0 and acc=0.
  - Reset mid-frame discards the partial frame; no done pulse is produced.
- Fibonacci classifier, combinational, shared:
  - in_data belongs to {0,1,2,3,5,8,13} -> is_fib=1.
  - Any other value (4,6,7,9,10,11,12,14,15) -> is_fib=0.
- Handshake:
  - A sample is accepted on an edge where in_valid and in_ready are both 1.
  - in_valid may stay high across cycles; each high cycle with in_ready=1 is a separate sample.
  - in_ready is driven combinationally from state (COLLECT only). It does not depend on in_valid.
- States:
  - IDLE:
    - in_ready=0, busy=0.
    - start=1 -> COLLECT; clear idx and acc.
    - majority and fib_count keep the previous frame's values.
  - COLLECT:
    - in_ready=1, busy=1.
    - On acceptance: acc<=acc+is_fib, idx<=idx+1.
    - When the accepted sample is number N_INPUTS (idx==N_INPUTS-1 at the edge) -> DECIDE.
    - start is ignored.
  - DECIDE (exactly one cycle):
    - in_ready=0, busy=1.
    - Next edge: fib_count<=acc, majority<=(acc > N_INPUTS/2), done<=1, state<=IDLE.
  - done:
    - Registered pulse, high for exactly the first IDLE cycle after DECIDE.
    - Cleared on the following edge.
- Latency: if the last sample is accepted at edge k, done, majority and fib_count are valid in the cycle after edge k+1.
- Boundaries:
  - start asserted in the same cycle done is high (IDLE) is honoured: next cycle is COLLECT and done drops.
  - Cycles with in_valid=0 in COLLECT stall without limit; no timeout.
  - acc cannot overflow: CW covers N_INPUTS.
  - N_INPUTS=1 goes COLLECT -> DECIDE after one sample.
  - Minimum frame length is N_INPUTS+2 cycles from the start edge to the done cycle.

Optional Feature:
FIB_MAJ_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge in COLLECT or DECIDE -> IDLE, idx/acc cleared, no done pulse.
  - majority and fib_count keep the previous frame's values.
  - abort overrides a coincident sample acceptance.
  - abort is ignored in IDLE.
  - rst has priority over abort.
- Undefined: no abort port; a frame always runs to completion or reset.

Test Plan:
1. rst=1 for 2 cycles, then release with start=0 -> all outputs 0, in_ready=0, busy=0; hold 5 cycles, nothing changes.
2. start, then 13 back-to-back samples 0,1,2,3,5,8,13,4,6,7,9,10,11 -> fib_count=7, majority=1, done high exactly once, 2 cycles after the last accept edge.
3. start, then 13 samples 4,6,7,9,10,11,12,14,15,13,0,1,2 with in_valid=0 gaps of 1-3 cycles between samples -> fib_count=4, majority=0; busy high throughout; in_ready never drops during the gaps.
4. Frame of six Fibonacci and seven non-Fibonacci values (boundary below threshold) -> fib_count=6, majority=0. Then assert start in the done cycle with 13x value 8 -> second frame fib_count=13, majority=1.
5. Start a frame and feed 5 samples, assert rst for one cycle, then run a full frame of all 15s -> no done from the aborted frame, fib_count=0, majority=0. With FIB_MAJ_ABORT_EN: same sequence using abort in place of rst, with the previous frame's results retained until the new done.
6. start pulsed while in COLLECT at sample 7 of 13 -> ignored; frame completes normally after 13 accepts with the correct count.

Source files
------------

// File: rtl/fib_majority_sequencer.sv
// Serial Fibonacci-majority check over N_INPUTS 4-bit samples; optional abort input under FIB_MAJ_ABORT_EN.
// Latency: result two edges after the last accept; in_ready is high only in COLLECT, so the source stalls freely.
module fib_majority_sequencer #(
  parameter int N_INPUTS = 13,
  parameter int CW       = $clog2(N_INPUTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [3:0]    in_data,
`ifdef FIB_MAJ_ABORT_EN
  input  logic          abort,
`endif
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          majority,
  output logic [CW-1:0] fib_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DECIDE  = 2'd2;

  localparam logic [CW-1:0] HALF     = CW'(N_INPUTS / 2);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_INPUTS - 1);

  logic [1:0]    state;
  logic [CW-1:0] idx;
  logic [CW-1:0] acc;
  logic          is_fib;
  logic          accept;

  // Single shared classifier; only 4-bit Fibonacci values qualify.
  always_comb begin
    is_fib = 1'b0;
    case (in_data)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13: is_fib = 1'b1;
      default:                                   is_fib = 1'b0;
    endcase
  end

  assign in_ready = (state == S_COLLECT);
  assign busy     = (state == S_COLLECT) || (state == S_DECIDE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      acc       <= '0;
      done      <= 1'b0;
      majority  <= 1'b0;
      fib_count <= '0;
    end else begin
      done <= 1'b0;
`ifdef FIB_MAJ_ABORT_EN
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
        idx   <= '0;
        acc   <= '0;
      end else
`endif
      begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_COLLECT;
              idx   <= '0;
              acc   <= '0;
            end
          end
          S_COLLECT: begin
            if (accept) begin
              acc <= acc + CW'(is_fib);
              idx <= idx + CW'(1);
              if (idx == LAST_IDX) state <= S_DECIDE;
            end
          end
          S_DECIDE: begin
            fib_count <= acc;
            majority  <= (acc > HALF);
            done      <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
